// File: rtl/jt51_lin2log_if.sv
// Request/result bundle for the jt51_lin2log converter.
// The master drives the request side (cen, start, lin); the slave drives the result side.
interface jt51_lin2log_if;
  logic        cen;
  logic        start;
  logic [15:0] lin;
  logic        busy;
  logic        valid;
  logic [11:0] lg;
  logic        zero;

  modport master (output cen, start, lin, input busy, valid, lg, zero);
  modport slave  (input cen, start, lin, output busy, valid, lg, zero);
endinterface

// File: rtl/jt51_lin2log.sv
// Linear-to-log2 converter: normalise, then bit-serial squaring into a 4.8 result.
// Optional macro JT51_LIN2LOG_ROUND_EN adds a guard-bit squaring step and rounds the result (saturating).
module jt51_lin2log (
  input  logic          clk,
  input  logic          rst,
  jt51_lin2log_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SQR  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef JT51_LIN2LOG_ROUND_EN
  localparam logic [3:0] LAST_ITER = 4'd8;
`else
  localparam logic [3:0] LAST_ITER = 4'd7;
`endif

  logic [1:0]  state_q, state_d;
  logic [15:0] lin_q, lin_d;
  logic [15:0] m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  int_q, int_d;
  logic [7:0]  frac_q, frac_d;
  logic        zflag_q, zflag_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [11:0] lg_q, lg_d;
  logic        zero_q, zero_d;
`ifdef JT51_LIN2LOG_ROUND_EN
  logic        guard_q, guard_d;
  logic [12:0] lg_sum;
`endif

  logic [3:0]  msb_pos;
  logic [31:0] prod;
  logic        sq_bit;
  logic [15:0] m_sq;
  logic        unused_prod;

  always_comb begin
    msb_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (lin_q[i]) msb_pos = 4'(i);
    end
  end

  // Single shared multiplier: m is Q1.15, so m*m is Q2.30 and bit 31 decides the next log bit.
  assign prod        = {16'd0, m_q} * {16'd0, m_q};
  assign sq_bit      = prod[31];
  assign m_sq        = sq_bit ? prod[31:16] : prod[30:15];
  assign unused_prod = ^prod[14:0];

`ifdef JT51_LIN2LOG_ROUND_EN
  assign lg_sum = {1'b0, int_q, frac_q} + {12'd0, guard_q};
`endif

  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    int_d   = int_q;
    frac_d  = frac_q;
    zflag_d = zflag_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    lg_d    = lg_q;
    zero_d  = zero_q;
`ifdef JT51_LIN2LOG_ROUND_EN
    guard_d = guard_q;
`endif
    if (bus.cen) begin
      valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            lin_d   = bus.lin;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_d   = 4'd0;
          frac_d  = 8'd0;
`ifdef JT51_LIN2LOG_ROUND_EN
          guard_d = 1'b0;
`endif
          // A zero input still runs the squaring steps (m=0 yields 0 bits) so latency stays fixed.
          if (lin_q == 16'd0) begin
            int_d   = 4'd0;
            m_d     = 16'd0;
            zflag_d = 1'b1;
          end else begin
            int_d   = msb_pos;
            m_d     = lin_q << (4'd15 - msb_pos);
            zflag_d = 1'b0;
          end
          state_d = S_SQR;
        end
        S_SQR: begin
          m_d   = m_sq;
          cnt_d = cnt_q + 4'd1;
`ifdef JT51_LIN2LOG_ROUND_EN
          if (cnt_q == LAST_ITER) guard_d = sq_bit;
          else                    frac_d  = {frac_q[6:0], sq_bit};
`else
          frac_d = {frac_q[6:0], sq_bit};
`endif
          if (cnt_q == LAST_ITER) state_d = S_DONE;
        end
        default: begin
`ifdef JT51_LIN2LOG_ROUND_EN
          lg_d = lg_sum[12] ? 12'hFFF : lg_sum[11:0];
`else
          lg_d = {int_q, frac_q};
`endif
          zero_d  = zflag_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lin_q   <= 16'd0;
      m_q     <= 16'd0;
      cnt_q   <= 4'd0;
      int_q   <= 4'd0;
      frac_q  <= 8'd0;
      zflag_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      lg_q    <= 12'd0;
      zero_q  <= 1'b0;
`ifdef JT51_LIN2LOG_ROUND_EN
      guard_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      zflag_q <= zflag_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      lg_q    <= lg_d;
      zero_q  <= zero_d;
`ifdef JT51_LIN2LOG_ROUND_EN
      guard_q <= guard_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.lg    = lg_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_jt51_lin2log.sv
// Self-checking bench for jt51_lin2log: scoreboard of expected {zero,lg} per accepted start.
// Build with +define+JT51_LIN2LOG_ROUND_EN to check the rounding variant.
module tb_jt51_lin2log;

`ifdef JT51_LIN2LOG_ROUND_EN
  localparam int LAT = 11;
  localparam logic [11:0] LG_OF_3 = 12'h196;
`else
  localparam int LAT = 10;
  localparam logic [11:0] LG_OF_3 = 12'h195;
`endif

  typedef struct packed {
    logic        zero;
    logic [11:0] lg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  jt51_lin2log_if bus ();

  jt51_lin2log dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cen_div = 1;
  logic last_cen = 1'b0;
  int   vcount = 0;
  exp_t sb[$];

  always @(posedge clk) begin
    if (bus.cen && bus.valid) vcount <= vcount + 1;
  end

  // Reference: normalise, then 8 (or 9) truncated squarings of a Q1.15 mantissa.
  function automatic exp_t model(input int v);
    exp_t   r;
    int     p;
    int     res;
    longint m;
    longint sq;
    int     b;
    r.zero = (v == 0);
    r.lg   = 12'd0;
    if (v == 0) return r;
    p = 0;
    for (int k = 0; k < 16; k++) if ((v >> k) & 1) p = k;
    m = longint'(v) << (15 - p);
    res = p * 256;
    for (int k = 0; k < LAT - 2; k++) begin
      sq = m * m;
      b  = int'((sq >> 31) & 1);
      m  = (b == 1) ? (sq >> 16) : ((sq >> 15) & 64'hFFFF);
      if (k < 8) res = res + (b << (7 - k));
      else       res = res + b;
    end
    if (res > 4095) res = 4095;
    r.lg = 12'(res);
    return r;
  endfunction

  task automatic tick();
    last_cen = bus.cen;
    @(posedge clk);
    #1;
    cyc++;
    bus.cen = (cen_div <= 1) ? 1'b1 : ((cyc % cen_div) == 0);
  endtask

  task automatic do_start(input logic [15:0] v);
    bus.lin   = v;
    bus.start = 1'b1;
    do tick(); while (!last_cen);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < LAT + 6) begin
      tick();
      if (last_cen) n++;
      if (bus.valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.cen = 1'b1; bus.start = 1'b0; bus.lin = 16'd0;
    rst = 1'b1;
    tick(); tick();
    total++; if (bus.busy  !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.valid); end
    total++; if (bus.lg    !== 12'h0) begin bad++; $display("FAIL reset_lg got=%h want=000", bus.lg); end
    total++; if (bus.zero  !== 1'b0)  begin bad++; $display("FAIL reset_zero got=%0b want=0", bus.zero); end
    rst = 1'b0;
    tick();
    $display("reset released: busy=%0b valid=%0b lg=%h zero=%0b", bus.busy, bus.valid, bus.lg, bus.zero);
  endtask

  task automatic test_values();
    logic [15:0] vin[6];
    logic [11:0] vexp[6];
    logic        zexp[6];
    exp_t e;
    int   n;
    bit   ok;
    vin = '{16'h0001, 16'h0002, 16'h8000, 16'hFFFF, 16'h0003, 16'h0000};
    vexp = '{12'h000, 12'h100, 12'hF00, 12'hFFF, LG_OF_3, 12'h000};
    zexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(exp_t'({zexp[i], vexp[i]}));
      do_start(vin[i]);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_after_start lin=%h got=%0b want=1", vin[i], bus.busy); end
      wait_valid(n, ok);
      total++; if (!ok || n != LAT) begin bad++; $display("FAIL latency lin=%h got=%0d ok=%0b want=%0d", vin[i], n, ok, LAT); end
      e = sb.pop_front();
      total++; if (bus.lg !== e.lg) begin bad++; $display("FAIL value_lg lin=%h got=%h want=%h", vin[i], bus.lg, e.lg); end
      total++; if (bus.zero !== e.zero) begin bad++; $display("FAIL value_zero lin=%h got=%0b want=%0b", vin[i], bus.zero, e.zero); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_at_valid lin=%h got=%0b want=0", vin[i], bus.busy); end
      $display("conv lin=%h lg=%h zero=%0b cen_cycles=%0d", vin[i], bus.lg, bus.zero, n);
      tick();
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL valid_pulse lin=%h got=%0b want=0", vin[i], bus.valid); end
    end
    // zero flag was set by the last entry; a nonzero input must clear it
    sb.push_back(exp_t'({1'b0, LG_OF_3}));
    do_start(16'h0003);
    wait_valid(n, ok);
    e = sb.pop_front();
    total++; if (!ok || bus.zero !== e.zero || bus.lg !== e.lg) begin bad++; $display("FAIL zero_clear got=%0b/%h ok=%0b want=%0b/%h", bus.zero, bus.lg, ok, e.zero, e.lg); end
    $display("conv lin=0003 after zero: lg=%h zero=%0b", bus.lg, bus.zero);
    tick();
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   n;
    int   v0;
    bit   ok;
    v0 = vcount;
    sb.push_back(exp_t'({1'b0, LG_OF_3}));
    do_start(16'h0003);
    for (int k = 0; k < 3; k++) begin
      do tick(); while (!last_cen);
    end
    do_start(16'h8000);
    wait_valid(n, ok);
    e = sb.pop_front();
    total++; if (!ok || bus.lg !== e.lg) begin bad++; $display("FAIL busy_ignore_lg got=%h ok=%0b want=%h", bus.lg, ok, e.lg); end
    for (int k = 0; k < LAT + 5; k++) tick();
    total++; if (vcount - v0 != 1) begin bad++; $display("FAIL busy_ignore_count got=%0d want=1", vcount - v0); end
    $display("busy ignore: lg=%h valid_pulses=%0d", bus.lg, vcount - v0);
  endtask

  task automatic test_cen();
    exp_t e;
    int   n;
    bit   ok;
    cen_div = 4;
    sb.push_back(exp_t'({1'b0, LG_OF_3}));
    do_start(16'h0003);
    wait_valid(n, ok);
    e = sb.pop_front();
    total++; if (!ok || n != LAT) begin bad++; $display("FAIL cen_latency got=%0d ok=%0b want=%0d", n, ok, LAT); end
    total++; if (bus.lg !== e.lg) begin bad++; $display("FAIL cen_lg got=%h want=%h", bus.lg, e.lg); end
    tick();
    total++; if (last_cen || bus.valid !== 1'b1) begin bad++; $display("FAIL cen_stretch got=%0b want=1", bus.valid); end
    do tick(); while (!last_cen);
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL cen_clear got=%0b want=0", bus.valid); end
    $display("cen 1-of-4: lg=%h cen_cycles=%0d", e.lg, n);
    cen_div = 1;
    bus.cen = 1'b1;
  endtask

  task automatic test_abort();
    exp_t e;
    int   n;
    int   v0;
    bit   ok;
    v0 = vcount;
    do_start(16'h0003);
    for (int k = 0; k < 5; k++) begin
      do tick(); while (!last_cen);
    end
    rst = 1'b1;
    #1;
    total++; if ({bus.busy, bus.valid, bus.zero} !== 3'b000) begin bad++; $display("FAIL abort_flags got=%b want=000", {bus.busy, bus.valid, bus.zero}); end
    total++; if (bus.lg !== 12'h000) begin bad++; $display("FAIL abort_lg got=%h want=000", bus.lg); end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < LAT + 5; k++) tick();
    total++; if (vcount != v0 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_no_valid pulses=%0d busy=%0b want=0/0", vcount - v0, bus.busy); end
    sb.push_back(exp_t'({1'b0, 12'hF00}));
    do_start(16'h8000);
    wait_valid(n, ok);
    e = sb.pop_front();
    total++; if (!ok || bus.lg !== e.lg) begin bad++; $display("FAIL abort_restart got=%h ok=%0b want=%h", bus.lg, ok, e.lg); end
    $display("abort then lin=8000: lg=%h", bus.lg);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    int   v;
    int   nconv;
    bit   ok;
    real  ideal;
    real  diff;
    nconv = 0;
    v = 1;
    sb.push_back(model(v));
    do_start(16'(v));
    while (sb.size() > 0) begin
      wait_valid(n, ok);
      e = sb.pop_front();
      total++;
      if (!ok || n != LAT || bus.lg !== e.lg || bus.zero !== e.zero) begin
        bad++;
        $display("FAIL sweep lin=%h got=%h/%0b n=%0d want=%h/%0b n=%0d", v, bus.lg, bus.zero, n, e.lg, e.zero, LAT);
      end
      ideal = $ln(real'(v)) / $ln(2.0) * 256.0;
      diff  = real'(bus.lg) - ideal;
      total++;
      if (diff >= 2.0 || diff <= -2.0) begin
        bad++;
        $display("FAIL log_error lin=%h got=%h want_approx=%f", v, bus.lg, ideal);
      end
      nconv++;
      if ((nconv % 256) == 0) $display("sweep lin=%h lg=%h", v, bus.lg);
      v = v + 23;
      if (v <= 65535) begin
        sb.push_back(model(v));
        do_start(16'(v));
      end else if (v < 65535 + 23) begin
        v = 65535;
        sb.push_back(model(v));
        do_start(16'(v));
        v = 65535 + 23;
      end
      if (!ok) break;
    end
    $display("sweep done: %0d conversions", nconv);
  endtask

  initial begin
    bus.cen   = 1'b1;
    bus.start = 1'b0;
    bus.lin   = 16'd0;
    test_reset();
    test_values();
    test_busy_ignore();
    test_cen();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
